// File: rtl/multicycle_controller.sv
// multicycle_controller
// ---------------------
// Main control FSM for a multi-cycle RV32I core. Each instruction goes
// through FETCH, DECODE, EXEC, and then MEM and/or WB as its class needs.
// The FSM drives the ALU-op class, the register-file, PC, IR and data-memory
// strobes, and counts retired instructions.
//
// Both memories can insert wait states. FETCH holds until imem_ack arrives,
// and MEM holds until dmem_ack arrives. An unknown opcode sends the FSM to
// TRAP, where it stays until reset.
//
// Parameters
//   CNT_W         width of the retired-instruction counter (wraps)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         leave IDLE and begin fetching (sampled in IDLE)
//   opcode        instr[6:0] from the IR, valid from DECODE onward
//   branch_taken  branch-condition result from the datapath, valid in EXEC
//   imem_ack      instruction memory returns data this cycle
//   dmem_ack      data memory access completes this cycle
//   imem_req      instruction fetch request
//   ir_we         instruction register load
//   pc_we         PC write enable
//   pc_sel        PC source: 0 = PC+4, 1 = ALU target
//   alu_op        00 add (LW/SW/AUIPC), 01 branch, 10 R/I-type, 11 JAL/LUI
//   alu_src_b     ALU operand B: 0 = rs2, 1 = immediate
//   dmem_req      data memory request
//   dmem_we       1 = store, 0 = load (only meaningful with dmem_req)
//   reg_we        register-file write enable
//   wb_sel        write-back source: 00 ALU, 01 load data, 10 PC+4
//   busy          high in every state except IDLE and TRAP
//   halted        high in TRAP
//   retired       retired-instruction count
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [1:0]       alu_op,
  output logic             alu_src_b,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  // Opcode class. C_NONE marks an illegal opcode.
  typedef enum logic [3:0] {
    C_NONE,
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_LUI,
    C_AUIPC
  } class_t;

  state_t state;
  state_t state_next;
  class_t cls;      // class latched in DECODE
  class_t cls_dec;  // class decoded from the live opcode
  logic   retire;   // the current state is the instruction's last one and is exiting

  // Opcode classification
  always_comb begin
    cls_dec = C_NONE;
    case (opcode)
      7'b0110011: cls_dec = C_R;
      7'b0010011: cls_dec = C_I;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BRANCH;
      7'b1101111: cls_dec = C_JAL;
      7'b0110111: cls_dec = C_LUI;
      7'b0010111: cls_dec = C_AUIPC;
      default:    cls_dec = C_NONE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The class stays stable from EXEC until the instruction retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls <= C_NONE;
    end else if (state == S_DECODE) begin
      cls <= cls_dec;
    end
  end

  // Next-state logic and retire detection
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls_dec == C_NONE) begin
          state_next = S_TRAP;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: state_next = S_MEM;
          C_BRANCH: begin
            // A branch finishes in EXEC. The PC update happens here.
            state_next = S_FETCH;
            retire     = 1'b1;
          end
          default: state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (cls == C_STORE) begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode. This is Moore on state and latched class. The only
  // exceptions are the FETCH IR/PC strobes, which are gated by imem_ack,
  // and the branch PC write, which is gated by branch_taken.
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    alu_op    = 2'b00;
    alu_src_b = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'b00;
    busy      = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        ir_we    = imem_ack;
        pc_we    = imem_ack;
      end
      S_DECODE: begin
        busy = 1'b1;
      end
      S_EXEC: begin
        busy      = 1'b1;
        alu_src_b = 1'b1;
        case (cls)
          C_R: begin
            alu_op    = 2'b10;
            alu_src_b = 1'b0;
          end
          C_I: alu_op = 2'b10;
          C_BRANCH: begin
            alu_op    = 2'b01;
            alu_src_b = 1'b0;
            pc_sel    = 1'b1;
            pc_we     = branch_taken;
          end
          C_JAL: begin
            alu_op = 2'b11;
            pc_sel = 1'b1;
            pc_we  = 1'b1;
          end
          C_LUI:   alu_op = 2'b11;
          default: alu_op = 2'b00;
        endcase
      end
      S_MEM: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
      end
      S_WB: begin
        busy   = 1'b1;
        reg_we = 1'b1;
        case (cls)
          C_LOAD:  wb_sel = 2'b01;
          C_JAL:   wb_sel = 2'b10;
          default: wb_sel = 2'b00;
        endcase
      end
      S_TRAP: begin
        halted = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Retired-instruction counter. It wraps naturally at CNT_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller.
// Two instances share the same stimulus: a default-width one and a CNT_W=4
// one used to observe counter wrap. Inputs change 1 time unit after the
// rising edge, and outputs are sampled 1 unit later.
// The output vector layout is
// {imem_req, ir_we, pc_we, pc_sel, alu_op[1:0], alu_src_b,
//  dmem_req, dmem_we, reg_we, wb_sel[1:0], busy, halted}.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        imem_ack;
  logic        dmem_ack;

  logic        imem_req, ir_we, pc_we, pc_sel, alu_src_b, dmem_req, dmem_we, reg_we, busy, halted;
  logic [1:0]  alu_op, wb_sel;
  logic [31:0] retired;

  logic        imem_req4, ir_we4, pc_we4, pc_sel4, alu_src_b4, dmem_req4, dmem_we4, reg_we4, busy4, halted4;
  logic [1:0]  alu_op4, wb_sel4;
  logic [3:0]  retired4;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [31:0] exp_ret  = '0;
  logic [3:0]  exp_ret4 = '0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .branch_taken(branch_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .wb_sel(wb_sel), .busy(busy), .halted(halted), .retired(retired)
  );

  multicycle_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .branch_taken(branch_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req4), .ir_we(ir_we4), .pc_we(pc_we4), .pc_sel(pc_sel4),
    .alu_op(alu_op4), .alu_src_b(alu_src_b4), .dmem_req(dmem_req4), .dmem_we(dmem_we4),
    .reg_we(reg_we4), .wb_sel(wb_sel4), .busy(busy4), .halted(halted4), .retired(retired4)
  );

  wire [13:0] outs  = {imem_req, ir_we, pc_we, pc_sel, alu_op, alu_src_b,
                       dmem_req, dmem_we, reg_we, wb_sel, busy, halted};
  wire [13:0] outs4 = {imem_req4, ir_we4, pc_we4, pc_sel4, alu_op4, alu_src_b4,
                       dmem_req4, dmem_we4, reg_we4, wb_sel4, busy4, halted4};

  // Expected output vectors, hand-derived per state/class
  //                                  imr  irw  pcw  pcs  aluop src  dreq dwe  rwe  wbsel busy halt
  localparam logic [13:0] V_IDLE   = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0};
  localparam logic [13:0] V_F_WAIT = {1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_F_ACK  = {1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_DEC    = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_EX_R   = {1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_EX_I   = {1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_EX_ADD = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_EX_BT  = {1'b0,1'b0,1'b1,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_EX_BN  = {1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_EX_JAL = {1'b0,1'b0,1'b1,1'b1,2'b11,1'b1,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_EX_LUI = {1'b0,1'b0,1'b0,1'b0,2'b11,1'b1,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_MEM_LD = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_MEM_ST = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,1'b0,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_WB_ALU = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b00,1'b1,1'b0};
  localparam logic [13:0] V_WB_LD  = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,1'b0};
  localparam logic [13:0] V_WB_PC  = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,1'b0};
  localparam logic [13:0] V_TRAP   = {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1};

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Stimulus vector layout: {imem_ack, dmem_ack, branch_taken}

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; opcode = '0; branch_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #12;
    n_chk++;
    if (outs !== V_IDLE || outs4 !== V_IDLE) $display("FAIL reset_outs got=%b/%b exp=%b", outs, outs4, V_IDLE);
    else n_pass++;
    n_chk++;
    if (retired !== 32'd0 || retired4 !== 4'd0) $display("FAIL reset_retired got=%0d/%0d exp=0", retired, retired4);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // With start low, the FSM stays in IDLE even when acks are present
    imem_ack = 1'b1; dmem_ack = 1'b1; #1;
    n_chk++;
    if (outs !== V_IDLE || outs4 !== V_IDLE) $display("FAIL idle_hold got=%b/%b exp=%b", outs, outs4, V_IDLE);
    else n_pass++;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [2:0]  st [4];
    logic [13:0] ev [4];
    opcode = OP_R;
    // A stray dmem_ack in DECODE and a stray imem_ack in EXEC/WB must be ignored
    st = '{3'b100, 3'b010, 3'b100, 3'b110};
    ev = '{V_F_ACK, V_DEC, V_EX_R, V_WB_ALU};
    for (int i = 0; i < 4; i++) begin
      {imem_ack, dmem_ack, branch_taken} = st[i]; #1;
      n_chk++;
      if (outs !== ev[i] || outs4 !== ev[i]) $display("FAIL rtype_c%0d got=%b/%b exp=%b", i, outs, outs4, ev[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    {imem_ack, dmem_ack, branch_taken} = 3'b000;
    exp_ret++; exp_ret4++;
    n_chk++;
    if (retired !== exp_ret || retired4 !== exp_ret4) $display("FAIL rtype_retired got=%0d/%0d exp=%0d/%0d", retired, retired4, exp_ret, exp_ret4);
    else n_pass++;
  endtask

  task automatic test_load_wait();
    logic [2:0]  st [8];
    logic [13:0] ev [8];
    opcode = OP_LD;
    st = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000};
    ev = '{V_F_ACK, V_DEC, V_EX_ADD, V_MEM_LD, V_MEM_LD, V_MEM_LD, V_MEM_LD, V_WB_LD};
    for (int i = 0; i < 8; i++) begin
      {imem_ack, dmem_ack, branch_taken} = st[i]; #1;
      n_chk++;
      if (outs !== ev[i] || outs4 !== ev[i]) $display("FAIL load_c%0d got=%b/%b exp=%b", i, outs, outs4, ev[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    {imem_ack, dmem_ack, branch_taken} = 3'b000;
    exp_ret++; exp_ret4++;
    n_chk++;
    if (retired !== exp_ret || retired4 !== exp_ret4) $display("FAIL load_retired got=%0d/%0d exp=%0d/%0d", retired, retired4, exp_ret, exp_ret4);
    else n_pass++;
  endtask

  task automatic test_branch();
    logic [2:0]  st [2][3];
    logic [13:0] ev [2][3];
    opcode = OP_BR;
    st[0] = '{3'b100, 3'b000, 3'b001};
    ev[0] = '{V_F_ACK, V_DEC, V_EX_BT};
    st[1] = '{3'b100, 3'b001, 3'b000};
    ev[1] = '{V_F_ACK, V_DEC, V_EX_BN};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        {imem_ack, dmem_ack, branch_taken} = st[k][i]; #1;
        n_chk++;
        if (outs !== ev[k][i] || outs4 !== ev[k][i]) $display("FAIL branch%0d_c%0d got=%b/%b exp=%b", k, i, outs, outs4, ev[k][i]);
        else n_pass++;
        @(posedge clk); #1;
      end
      {imem_ack, dmem_ack, branch_taken} = 3'b000;
      exp_ret++; exp_ret4++;
      n_chk++;
      if (retired !== exp_ret || retired4 !== exp_ret4) $display("FAIL branch%0d_retired got=%0d/%0d exp=%0d/%0d", k, retired, retired4, exp_ret, exp_ret4);
      else n_pass++;
    end
  endtask

  task automatic test_jal_fetch_wait();
    logic [2:0]  st [6];
    logic [13:0] ev [6];
    opcode = OP_JAL;
    st = '{3'b000, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000};
    ev = '{V_F_WAIT, V_F_WAIT, V_F_ACK, V_DEC, V_EX_JAL, V_WB_PC};
    for (int i = 0; i < 6; i++) begin
      {imem_ack, dmem_ack, branch_taken} = st[i]; #1;
      n_chk++;
      if (outs !== ev[i] || outs4 !== ev[i]) $display("FAIL jal_c%0d got=%b/%b exp=%b", i, outs, outs4, ev[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    {imem_ack, dmem_ack, branch_taken} = 3'b000;
    exp_ret++; exp_ret4++;
    n_chk++;
    if (retired !== exp_ret || retired4 !== exp_ret4) $display("FAIL jal_retired got=%0d/%0d exp=%0d/%0d", retired, retired4, exp_ret, exp_ret4);
    else n_pass++;
  endtask

  task automatic test_other_classes();
    logic [6:0]  ops [4];
    logic [2:0]  st  [4][4];
    logic [13:0] ev  [4][4];
    ops   = '{OP_I, OP_LUI, OP_AUI, OP_ST};
    st[0] = '{3'b100, 3'b000, 3'b000, 3'b000};
    ev[0] = '{V_F_ACK, V_DEC, V_EX_I, V_WB_ALU};
    st[1] = '{3'b100, 3'b000, 3'b000, 3'b000};
    ev[1] = '{V_F_ACK, V_DEC, V_EX_LUI, V_WB_ALU};
    st[2] = '{3'b100, 3'b000, 3'b000, 3'b000};
    ev[2] = '{V_F_ACK, V_DEC, V_EX_ADD, V_WB_ALU};
    st[3] = '{3'b100, 3'b000, 3'b000, 3'b010};
    ev[3] = '{V_F_ACK, V_DEC, V_EX_ADD, V_MEM_ST};
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k];
      for (int i = 0; i < 4; i++) begin
        {imem_ack, dmem_ack, branch_taken} = st[k][i]; #1;
        n_chk++;
        if (outs !== ev[k][i] || outs4 !== ev[k][i]) $display("FAIL class%0d_c%0d got=%b/%b exp=%b", k, i, outs, outs4, ev[k][i]);
        else n_pass++;
        @(posedge clk); #1;
      end
      {imem_ack, dmem_ack, branch_taken} = 3'b000;
      exp_ret++; exp_ret4++;
      n_chk++;
      if (retired !== exp_ret || retired4 !== exp_ret4) $display("FAIL class%0d_retired got=%0d/%0d exp=%0d/%0d", k, retired, retired4, exp_ret, exp_ret4);
      else n_pass++;
    end
  endtask

  // 16 back-to-back R-types push the 4-bit counter through its 15 -> 0 wrap
  task automatic test_back_to_back_wrap();
    opcode = OP_R;
    for (int n = 0; n < 16; n++) begin
      imem_ack = 1'b1;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_ret++; exp_ret4++;
      n_chk++;
      if (retired !== exp_ret || retired4 !== exp_ret4) $display("FAIL wrap_n%0d_retired got=%0d/%0d exp=%0d/%0d", n, retired, retired4, exp_ret, exp_ret4);
      else n_pass++;
    end
  endtask

  task automatic test_trap();
    opcode = OP_BAD;
    imem_ack = 1'b1; #1;
    n_chk++;
    if (outs !== V_F_ACK || outs4 !== V_F_ACK) $display("FAIL trap_fetch got=%b/%b exp=%b", outs, outs4, V_F_ACK);
    else n_pass++;
    @(posedge clk); #1;
    imem_ack = 1'b0; #1;
    n_chk++;
    if (outs !== V_DEC || outs4 !== V_DEC) $display("FAIL trap_decode got=%b/%b exp=%b", outs, outs4, V_DEC);
    else n_pass++;
    @(posedge clk); #1;
    // start stays high and acks toggle, but TRAP must hold with no strobes
    for (int i = 0; i < 20; i++) begin
      {imem_ack, dmem_ack, branch_taken} = 3'(i % 8); #1;
      n_chk++;
      if (outs !== V_TRAP || outs4 !== V_TRAP) $display("FAIL trap_c%0d got=%b/%b exp=%b", i, outs, outs4, V_TRAP);
      else n_pass++;
      @(posedge clk); #1;
    end
    {imem_ack, dmem_ack, branch_taken} = 3'b000;
    n_chk++;
    if (retired !== exp_ret || retired4 !== exp_ret4) $display("FAIL trap_retired got=%0d/%0d exp=%0d/%0d", retired, retired4, exp_ret, exp_ret4);
    else n_pass++;
    rst_n = 1'b0; #2;
    exp_ret = '0; exp_ret4 = '0;
    n_chk++;
    if (outs !== V_IDLE || retired !== 32'd0 || retired4 !== 4'd0) $display("FAIL trap_reset got=%b ret=%0d/%0d exp=%b ret=0", outs, retired, retired4, V_IDLE);
    else n_pass++;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (outs !== V_IDLE || outs4 !== V_IDLE) $display("FAIL trap_idle got=%b/%b exp=%b", outs, outs4, V_IDLE);
    else n_pass++;
    start = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mem();
    opcode = OP_LD;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if (outs !== V_MEM_LD || outs4 !== V_MEM_LD) $display("FAIL midmem_inmem got=%b/%b exp=%b", outs, outs4, V_MEM_LD);
    else n_pass++;
    // Reset lands between clock edges, so outputs must drop without waiting for an edge
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (dmem_req !== 1'b0 || outs !== V_IDLE || outs4 !== V_IDLE) $display("FAIL midmem_reset got=%b/%b exp=%b", outs, outs4, V_IDLE);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_jal_fetch_wait();
    test_other_classes();
    test_back_to_back_wrap();
    test_trap();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
